sccb_write_ctrl: RTL and testbench

Transaction sequencer for the OV7670 SCCB/I2C configuration port.
- Accepts one register-write request (register address and data).
- Emits START, then three bytes MSB-first, each followed by an ACK slot: device ID, register address, data. Ends with STOP.
- Generates its own SCL from a clock-enable divider and drives SDA as open-drain (output value plus output-enable).
- Sits between the camera init ROM walker and the camera pins.

---
 rtl/sccb_write_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sccb_write_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_write_ctrl.sv
// SCCB register-write sequencer for the OV7670: START, device ID, register, data, STOP.
// Optional macro SCCB_RETRY_EN re-sends the whole transaction after a NACK, up to RETRY_LIMIT times.
module sccb_write_ctrl #(
  parameter int         CLK_DIV  = 250,
  parameter logic [7:0] DEV_ADDR = 8'h42
`ifdef SCCB_RETRY_EN
  , parameter int       RETRY_LIMIT = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_out,
  output logic       sda_oe,
  input  logic       sda_in
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  state_t        state;
  logic [DW-1:0] div;
  logic [1:0]    q;
  logic [2:0]    bitidx;
  logic [1:0]    byteidx;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic          qtick;

`ifdef SCCB_RETRY_EN
  localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  logic [RW-1:0] retries;
`endif

  assign qtick   = busy && (div == DW'(CLK_DIV - 1));
  assign sda_out = 1'b0;

  function automatic logic bit_of(input logic [1:0] b, input logic [2:0] i);
    case (b)
      2'd0:    bit_of = DEV_ADDR[i];
      2'd1:    bit_of = addr_q[i];
      default: bit_of = data_q[i];
    endcase
  endfunction

  function automatic logic scl_of(input state_t st, input logic [1:0] qq);
    case (st)
      START:   scl_of = (qq < 2'd2);
      BIT,
      ACK:     scl_of = (qq == 2'd1) || (qq == 2'd2);
      STOP:    scl_of = (qq != 2'd0);
      default: scl_of = 1'b1;
    endcase
  endfunction

  function automatic logic oe_of(input state_t st, input logic [1:0] qq, input logic bv);
    case (st)
      START:   oe_of = (qq != 2'd0);
      BIT:     oe_of = !bv;
      STOP:    oe_of = (qq < 2'd2);
      default: oe_of = 1'b0;
    endcase
  endfunction

  // Outputs are registered from the quarter/state being entered, so pins change on the qtick edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div     <= '0;
      q       <= '0;
      bitidx  <= '0;
      byteidx <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
`ifdef SCCB_RETRY_EN
      retries <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (busy) div <= qtick ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          if (start_req) begin
            addr_q  <= reg_addr;
            data_q  <= reg_data;
            ack_err <= 1'b0;
            busy    <= 1'b1;
            div     <= '0;
            q       <= '0;
            state   <= START;
`ifdef SCCB_RETRY_EN
            retries <= '0;
`endif
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (qtick) begin
            if (state == ACK && q == 2'd2 && sda_in) ack_err <= 1'b1;
            if (q != 2'd3) begin
              q      <= q + 2'd1;
              scl    <= scl_of(state, q + 2'd1);
              sda_oe <= oe_of(state, q + 2'd1, bit_of(byteidx, bitidx));
            end else begin
              q <= '0;
              case (state)
                START: begin
                  state   <= BIT;
                  byteidx <= '0;
                  bitidx  <= 3'd7;
                  scl     <= 1'b0;
                  sda_oe  <= !DEV_ADDR[7];
                end
                BIT: begin
                  scl <= 1'b0;
                  if (bitidx == 3'd0) begin
                    state  <= ACK;
                    sda_oe <= 1'b0;
                  end else begin
                    bitidx <= bitidx - 3'd1;
                    sda_oe <= !bit_of(byteidx, bitidx - 3'd1);
                  end
                end
                ACK: begin
                  scl <= 1'b0;
                  if (byteidx != 2'd2) begin
                    byteidx <= byteidx + 2'd1;
                    bitidx  <= 3'd7;
                    state   <= BIT;
                    sda_oe  <= !bit_of(byteidx + 2'd1, 3'd7);
                  end else begin
                    state  <= STOP;
                    sda_oe <= 1'b1;
                  end
                end
                STOP: begin
                  scl    <= 1'b1;
                  sda_oe <= 1'b0;
`ifdef SCCB_RETRY_EN
                  // A NACKed attempt restarts straight from STOP while busy stays high.
                  if (ack_err && retries != RW'(RETRY_LIMIT)) begin
                    retries <= retries + 1'b1;
                    ack_err <= 1'b0;
                    state   <= START;
                  end else begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end
`else
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_write_ctrl.sv
// Scoreboard bench for sccb_write_ctrl: a bus decoder/device model pops expected bytes and completions.
module tb_sccb_write_ctrl;

  localparam int CLK_DIV = 2;
  localparam int LEN     = 116 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_req = 1'b0;
  logic [7:0] reg_addr = '0;
  logic [7:0] reg_data = '0;
  logic       busy, done, ack_err, scl, sda_out, sda_oe, sda_in;
  logic       devdrv = 1'b0;

  assign sda_in = (sda_oe ? sda_out : 1'b1) & ~devdrv;

  sccb_write_ctrl #(
    .CLK_DIV(CLK_DIV),
    .DEV_ADDR(8'h42)
`ifdef SCCB_RETRY_EN
    , .RETRY_LIMIT(3)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .reg_addr(reg_addr), .reg_data(reg_data),
    .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda_out(sda_out), .sda_oe(sda_oe),
    .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   len;
    logic err;
    int   starts;
  } done_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] expBytes[$];
  done_t      expDone[$];
  int         nackByte = -1;
  int         nackAttempts = 0;
  int         planBase = 0;

  int         startCount = 0;
  int         startsSince = 0;
  int         stopsSince = 0;
  int         busyLen = 0;
  int         bitCnt = 0;
  int         byteNo = 0;
  logic [7:0] shiftReg = '0;
  logic       prevScl = 1'b1;
  logic       prevSda = 1'b1;
  done_t      d;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Bus decoder and ACKing device; it also owns the scoreboard queues' pop side.
  always @(negedge clk) begin
    if (reset) begin
      prevScl = 1'b1;
      prevSda = 1'b1;
      bitCnt = 0;
      byteNo = 0;
      devdrv = 1'b0;
      startsSince = 0;
      stopsSince = 0;
      busyLen = 0;
    end else begin
      if (busy) busyLen++;
      if (prevScl && scl && prevSda && !sda_in) begin
        startCount++;
        startsSince++;
        bitCnt = 0;
        byteNo = 0;
      end else if (prevScl && scl && !prevSda && sda_in) begin
        stopsSince++;
      end else if (!prevScl && scl) begin
        if (bitCnt < 8) begin
          shiftReg = {shiftReg[6:0], sda_in};
          bitCnt++;
          if (bitCnt == 8) begin
            if (expBytes.size() == 0) checkOutput("unexpected byte", {24'd0, shiftReg}, 32'hFFFF);
            else checkOutput("bus byte", {24'd0, shiftReg}, {24'd0, expBytes.pop_front()});
          end
        end
      end else if (prevScl && !scl) begin
        if (bitCnt == 8) begin
          devdrv = !((startCount - planBase - 1) < nackAttempts && byteNo == nackByte);
          bitCnt = 9;
        end else if (bitCnt == 9) begin
          devdrv = 1'b0;
          bitCnt = 0;
          byteNo++;
        end
      end
      if (done) begin
        if (expDone.size() == 0) begin
          checkOutput("unexpected done", 1, 0);
        end else begin
          d = expDone.pop_front();
          checkOutput("busy length", busyLen, d.len);
          checkOutput("ack_err at done", {31'd0, ack_err}, {31'd0, d.err});
          checkOutput("start count", startsSince, d.starts);
          checkOutput("stop count", stopsSince, d.starts);
        end
        busyLen = 0;
        startsSince = 0;
        stopsSince = 0;
      end
    end
    prevScl = scl;
    prevSda = sda_in;
  end

  task automatic waitDone(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic expectTxn(input logic [7:0] addr, input logic [7:0] data, input int attempts,
                           input logic err);
    for (int a = 0; a < attempts; a++) begin
      expBytes.push_back(8'h42);
      expBytes.push_back(addr);
      expBytes.push_back(data);
    end
    expDone.push_back('{LEN * attempts, err, attempts});
  endtask

  // One-cycle request; inputs are scrambled right after accept to prove they were latched.
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data, input int nByte,
                               input int nAtt, input int attempts, input logic err);
    expectTxn(addr, data, attempts, err);
    nackByte = nByte;
    nackAttempts = nAtt;
    planBase = startCount;
    @(posedge clk); #1;
    reg_addr = addr;
    reg_data = data;
    start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    reg_addr = ~addr;
    reg_data = ~data;
    waitDone(LEN * attempts + 20);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 0);
    checkOutput("reset done", {31'd0, done}, 0);
    checkOutput("reset ack_err", {31'd0, ack_err}, 0);
    checkOutput("reset scl", {31'd0, scl}, 1);
    checkOutput("reset sda_oe", {31'd0, sda_oe}, 0);
    checkOutput("reset sda_out", {31'd0, sda_out}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(8'h12, 8'h80, -1, 0, 1, 1'b0);

`ifdef SCCB_RETRY_EN
    applyStimulus(8'h6B, 8'h01, 1, 1, 2, 1'b0);
    applyStimulus(8'h55, 8'hAA, 0, 1, 2, 1'b0);
    applyStimulus(8'h0C, 8'h33, 2, 100, 4, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("ack_err sticky", {31'd0, ack_err}, 1);
`else
    applyStimulus(8'h6B, 8'h01, 1, 1, 1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("ack_err sticky", {31'd0, ack_err}, 1);
`endif
    applyStimulus(8'hA5, 8'h5A, -1, 0, 1, 1'b0);

    // Held request: re-accept only in the first IDLE cycle after DONE.
    expectTxn(8'h3A, 8'h04, 1, 1'b0);
    expectTxn(8'h3A, 8'h04, 1, 1'b0);
    nackByte = -1;
    nackAttempts = 0;
    planBase = startCount;
    @(posedge clk); #1;
    reg_addr = 8'h3A;
    reg_data = 8'h04;
    start_req = 1'b1;
    waitDone(LEN + 20);
    checkOutput("busy in done cycle", {31'd0, busy}, 0);
    @(negedge clk);
    checkOutput("busy in first idle", {31'd0, busy}, 0);
    @(negedge clk);
    checkOutput("busy after re-accept", {31'd0, busy}, 1);
    @(posedge clk); #1;
    start_req = 1'b0;
    waitDone(LEN + 20);

    // Abort at cycle 100 of a transfer; only the device-ID byte completes before that.
    expBytes.push_back(8'h42);
    planBase = startCount;
    @(posedge clk); #1;
    reg_addr = 8'h12;
    reg_data = 8'h80;
    start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("busy before abort", {31'd0, busy}, 1);
    repeat (98) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", {31'd0, busy}, 0);
    checkOutput("abort scl", {31'd0, scl}, 1);
    checkOutput("abort sda_oe", {31'd0, sda_oe}, 0);
    checkOutput("abort done", {31'd0, done}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(8'h11, 8'hC3, -1, 0, 1, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("leftover bytes", expBytes.size(), 0);
    checkOutput("leftover dones", expDone.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
